// File: rtl/alu_pkg.sv
// Shared encodings, FSM state constants and the latency lookup for the FP ALU issue controller.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_WAIT = 2'd1;
  localparam state_t S_RESP = 2'd2;

  localparam int unsigned DEF_LAT_ADD = 2;
  localparam int unsigned DEF_LAT_SUB = 2;
  localparam int unsigned DEF_LAT_MUL = 3;
  localparam int unsigned DEF_LAT_DIV = 8;

  // Counter preload for an op: the WAIT state spends LAT cycles counting down to zero.
  function automatic int unsigned lat_m1(input logic [1:0] op,
                                         input int unsigned la, input int unsigned ls,
                                         input int unsigned lm, input int unsigned ld);
    int unsigned r;
    case (op)
      OP_ADD:  r = la - 1;
      OP_SUB:  r = ls - 1;
      OP_MUL:  r = lm - 1;
      default: r = ld - 1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Initiator for the FP ALU: latches a command onto the ALU inputs, waits the op's
// latency, captures the result and hands it back with its tag.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned LAT_ADD = DEF_LAT_ADD,
  parameter int unsigned LAT_SUB = DEF_LAT_SUB,
  parameter int unsigned LAT_MUL = DEF_LAT_MUL,
  parameter int unsigned LAT_DIV = DEF_LAT_DIV,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [1:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_c,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_dz,
  output logic             busy
);

  localparam int unsigned LAT_MAX = (1 << CNT_W) - 1;

  if (LAT_ADD < 1 || LAT_ADD > LAT_MAX || LAT_SUB < 1 || LAT_SUB > LAT_MAX ||
      LAT_MUL < 1 || LAT_MUL > LAT_MAX || LAT_DIV < 1 || LAT_DIV > LAT_MAX) begin : g_lat_chk
    $error("alu_issue_ctrl: every LAT_* must be in 1..2**CNT_W-1");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   alu_a_q, alu_b_q, res_data_q, res_data_d;
  logic [1:0]         alu_op_q;
  logic [TAG_W-1:0]   tag_q;
  logic               dz_q, res_valid_q, res_valid_d;
  logic               accept, cmd_dz;

  assign cmd_ready = (state_q == S_IDLE) && !flush;
  assign accept    = cmd_valid && cmd_ready;
  // Either sign of zero counts as a zero divisor.
  assign cmd_dz    = (cmd_op == OP_DIV) && (cmd_b[WIDTH-2:0] == '0);

  // Next-state: flush overrides everything and drops whatever is in flight.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    if (flush) begin
      state_d     = S_IDLE;
      res_valid_d = 1'b0;
      cnt_d       = '0;
    end else begin
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          cnt_d   = CNT_W'(lat_m1(cmd_op, LAT_ADD, LAT_SUB, LAT_MUL, LAT_DIV));
          state_d = S_WAIT;
        end
        S_WAIT: if (cnt_q == '0) begin
          res_data_d  = alu_c;
          res_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        S_RESP: if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control state, counter and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  // Operand/tag capture: only an accepted command changes them; flush leaves them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OP_ADD;
      tag_q    <= '0;
      dz_q     <= 1'b0;
    end else if (accept) begin
      alu_a_q  <= cmd_a;
      alu_b_q  <= cmd_b;
      alu_op_q <= cmd_op;
      tag_q    <= cmd_tag;
      dz_q     <= cmd_dz;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_tag   = tag_q;
  assign res_dz    = dz_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: vector table plus hand sequences, results checked through a scoreboard.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, cmd_valid = 1'b0, res_ready = 1'b1;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic [1:0]  cmd_op = '0;
  logic [3:0]  cmd_tag = '0;
  logic        cmd_ready, res_valid, res_dz, busy;
  logic [31:0] alu_a, alu_b, alu_c, res_data;
  logic [1:0]  alu_op;
  logic [3:0]  res_tag;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_dz(res_dz), .busy(busy)
  );

  typedef struct {
    logic [1:0] op; logic [31:0] a; logic [31:0] b; logic [3:0] tag;
    logic [31:0] c; logic dz; int lat; int stall;
  } vec_t;
  typedef struct { vec_t v; int acc; } exp_t;

  exp_t sb[$];
  vec_t vt[9];
  int   nchk = 0, nerr = 0, cyc = 0, age = 0;
  logic rv_prev = 1'b0;

  function automatic vec_t mk(logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [3:0] tag,
                              logic [31:0] c, logic dz, int lat, int stall);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.tag = tag; v.c = c; v.dz = dz; v.lat = lat; v.stall = stall;
    return v;
  endfunction

  function automatic int tb_lat(logic [1:0] op);
    case (op)
      2'b00: return 2;
      2'b01: return 2;
      2'b10: return 3;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    case (op)
      2'b00: return (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : a + b;
      2'b01: return a - b;
      2'b10: return a * b;
      default: return a ^ b;
    endcase
  endfunction

  // ALU model: the result is only valid on the cycle the controller should sample it.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) age <= 0;
    else age <= age + 1;
  end
  always_comb alu_c = (age == tb_lat(alu_op) - 1) ? alu_fn(alu_a, alu_b, alu_op) : 32'hDEADBEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    nchk++; nerr++;
    $display("FAIL %s: got timeout/unexpected expected event", nm);
  endtask

  // Monitor: latency on result rise, operand stability in WAIT, contents on handshake.
  always @(negedge clk) begin
    if (rst) rv_prev <= 1'b0;
    else begin
      if (res_valid && !rv_prev) begin
        if (sb.size() == 0) fail("result_without_cmd");
        else chk("latency", cyc - sb[0].acc, sb[0].v.lat);
      end
      if (busy && !res_valid && sb.size() > 0) begin
        chk("wait_alu_a", alu_a, sb[0].v.a);
        chk("wait_alu_b", alu_b, sb[0].v.b);
        chk("wait_alu_op", {30'b0, alu_op}, {30'b0, sb[0].v.op});
      end
      if (res_valid && res_ready && !flush) begin
        if (sb.size() == 0) fail("handshake_without_cmd");
        else begin
          chk("res_data", res_data, sb[0].v.c);
          chk("res_tag", {28'b0, res_tag}, {28'b0, sb[0].v.tag});
          chk("res_dz", {31'b0, res_dz}, {31'b0, sb[0].v.dz});
          void'(sb.pop_front());
        end
      end
      rv_prev <= res_valid;
    end
  end

  task automatic push_exp(input vec_t v, output int acc);
    exp_t e;
    acc = cyc + 1;
    e.v = v; e.acc = acc;
    sb.push_back(e);
  endtask

  task automatic issue(input vec_t v, input bit hold, output int acc);
    int k;
    cmd_a = v.a; cmd_b = v.b; cmd_op = v.op; cmd_tag = v.tag; cmd_valid = 1'b1;
    acc = -1;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    if (k == 40) begin
      fail("cmd_accept");
      cmd_valid = 1'b0;
      return;
    end
    push_exp(v, acc);
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_rv();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    if (k == 40) fail("res_valid_wait");
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 60; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      fail("drain");
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, a0, a1, a2;
    vec_t v, v2;

    vt[0] = mk(2'b00, 32'h3F800000, 32'h40000000, 4'h3, 32'h40400000, 1'b0, 2, 0);
    vt[1] = mk(2'b01, 32'h00000010, 32'h00000003, 4'h5, 32'h0000000D, 1'b0, 2, 0);
    vt[2] = mk(2'b10, 32'h00000007, 32'h00000006, 4'h6, 32'h0000002A, 1'b0, 3, 0);
    vt[3] = mk(2'b11, 32'h12345678, 32'h80000000, 4'h9, 32'h92345678, 1'b1, 8, 0);
    vt[4] = mk(2'b11, 32'h0000FFFF, 32'h00000000, 4'hA, 32'h0000FFFF, 1'b1, 8, 0);
    vt[5] = mk(2'b11, 32'h00000001, 32'h3F800000, 4'hB, 32'h3F800001, 1'b0, 8, 0);
    vt[6] = mk(2'b11, 32'h000000F0, 32'h00000001, 4'hC, 32'h000000F1, 1'b0, 8, 0);
    vt[7] = mk(2'b10, 32'hFFFFFFFF, 32'h00000002, 4'hD, 32'hFFFFFFFE, 1'b0, 3, 5);
    vt[8] = mk(2'b01, 32'h00000000, 32'h00000001, 4'hF, 32'hFFFFFFFF, 1'b0, 2, 0);

    // Reset state
    #12;
    chk("rst_res_valid", {31'b0, res_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_alu_op", {30'b0, alu_op}, 32'h0);
    chk("rst_res_data", res_data, 32'h0);
    chk("rst_res_tag", {28'b0, res_tag}, 32'h0);
    chk("rst_res_dz", {31'b0, res_dz}, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < 9; i++) begin
      v = vt[i];
      if (v.stall > 0) begin
        res_ready = 1'b0;
        issue(v, 1'b0, acc);
        wait_rv();
        for (int k = 0; k < v.stall; k++) begin
          if (k > 0) @(negedge clk);
          chk("bp_data", res_data, v.c);
          chk("bp_tag", {28'b0, res_tag}, {28'b0, v.tag});
          chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'h0);
          chk("bp_busy", {31'b0, busy}, 32'h1);
          @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_ready_after", {31'b0, cmd_ready}, 32'h1);
        chk("bp_idle_after", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;
      end else begin
        issue(v, 1'b0, acc);
        drain();
      end
    end

    // Flush during divide WAIT with a new command waiting
    v  = mk(2'b11, 32'h11111111, 32'h80000000, 4'h7, 32'h91111111, 1'b1, 8, 0);
    v2 = mk(2'b00, 32'h00000020, 32'h00000022, 4'h8, 32'h00000042, 1'b0, 2, 0);
    issue(v, 1'b0, acc);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    cmd_a = v2.a; cmd_b = v2.b; cmd_op = v2.op; cmd_tag = v2.tag; cmd_valid = 1'b1;
    @(negedge clk);
    chk("flush_cmd_ready", {31'b0, cmd_ready}, 32'h0);
    sb.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {31'b0, busy}, 32'h0);
    chk("flush_no_valid", {31'b0, res_valid}, 32'h0);
    chk("flush_accept_next", {31'b0, cmd_ready}, 32'h1);
    push_exp(v2, acc);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    drain();

    // Flush in RESP with res_ready: result dropped
    v = mk(2'b00, 32'h00000005, 32'h00000006, 4'h1, 32'h0000000B, 1'b0, 2, 0);
    res_ready = 1'b0;
    issue(v, 1'b0, acc);
    wait_rv();
    @(posedge clk); #1;
    flush = 1'b1; res_ready = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flushR_valid", {31'b0, res_valid}, 32'h0);
    chk("flushR_busy", {31'b0, busy}, 32'h0);
    @(posedge clk); #1;

    // Asynchronous reset mid-RESP
    v = mk(2'b10, 32'h00000003, 32'h00000005, 4'h2, 32'h0000000F, 1'b0, 3, 0);
    res_ready = 1'b0;
    issue(v, 1'b0, acc);
    wait_rv();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, res_valid}, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_alu_a", alu_a, 32'h0);
    chk("arst_res_data", res_data, 32'h0);
    sb.delete();
    @(negedge clk); rst = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    v = mk(2'b11, 32'h00000100, 32'h00000002, 4'h4, 32'h00000102, 1'b0, 8, 0);
    issue(v, 1'b0, acc);
    drain();

    // Back-to-back with cmd_valid held high
    issue(mk(2'b01, 32'h00000009, 32'h00000004, 4'h0, 32'h00000005, 1'b0, 2, 0), 1'b1, a0);
    issue(mk(2'b10, 32'h00010000, 32'h00010000, 4'h1, 32'h00000000, 1'b0, 3, 0), 1'b1, a1);
    issue(mk(2'b00, 32'h00000001, 32'h00000001, 4'h2, 32'h00000002, 1'b0, 2, 0), 1'b0, a2);
    chk("b2b_gap_sub", a1 - a0, 32'd4);
    chk("b2b_gap_mul", a2 - a1, 32'd5);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
